yonga_lz4_stream_decoder: RTL and testbench
===========================================

// Module: yonga_lz4_stream_decoder
// PURPOSE
// Parametrised LZ4 block decoder with valid/ready streams on both sides and a
// configurable-depth circular history RAM (external, 1-cycle read latency).
// Consumes frames of [4-byte LE block size | block payload]... terminated by a
// 4-byte zero end mark, and emits decoded bytes. Sits between the input
// (compressed) FIFO and the output (decompressed) FIFO.
// PARAMETERS
// HIST_AW  7   history address width; window depth DEPTH = 2**HIST_AW bytes
// LEN_W    17  width of literal/match length counters
// BLK_W    31  width of remaining-block-byte counter
// PORTS
// clk          in   1        clock
// rstn         in   1        asynchronous, active-low reset
// i_enable     in   1        1 = decode allowed; 0 = pause (no in/hist traffic)
// i_in_valid   in   1        compressed byte available
// o_in_ready   out  1        controller accepts byte this cycle
// i_in_data    in   8        compressed byte
// o_out_valid  out  1        decoded byte valid
// i_out_ready  in   1        sink accepts decoded byte
// o_out_data   out  8        decoded byte
// o_hist_rd_en out  1        history read strobe
// o_hist_rd_addr out HIST_AW history read address
// i_hist_rd_data in 8        history read data, valid 1 clk after o_hist_rd_en
// o_hist_wr_en out  1        history write strobe
// o_hist_wr_addr out HIST_AW history write address
// o_hist_wr_data out 8       history write data
// o_idle       out  1        1 in IDLE
// o_block_done out  1        1-clk pulse when a block's last byte is emitted
// o_error      out  1        sticky decode error (macro only; else tied 0)
// BEHAVIOUR
// - Reset: all outputs 0 except o_idle=1; state IDLE; wr_ptr=0; counters 0.
// - Input transfer = i_in_valid & o_in_ready; output transfer = o_out_valid & i_out_ready.
// - o_in_ready=1 only in BSIZE/TOKEN/LIT_EXT/OFFSET/MAT_EXT/EOB, or in LIT/RAW
//   when output register empty or draining; always 0 if i_enable=0.
// - Output register: o_out_valid/o_out_data held stable until accepted. Each
//   emitted byte is written to history at wr_ptr in the same clk it is loaded
//   into the output register; wr_ptr += 1 mod DEPTH.
// - States: IDLE -> BSIZE when i_enable & i_in_valid. BSIZE takes 4 bytes LE;
//   bit31=1 -> RAW (uncompressed, size=bits30:0), else TOKEN. Size 0 -> EOB.
// - RAW: pass size bytes to output; after last -> EOB.
// - TOKEN: lit=tok[7:4], mlen=tok[3:0]+4; lit==15 -> LIT_EXT; lit==0 -> OFFSET;
//   else LIT. LIT_EXT: lit+=byte until byte!=0xFF.
// - LIT: emit lit bytes; if block remaining==0 after last literal -> EOB,
//   else OFFSET.
// - OFFSET: 2 bytes LE. off==0 -> sequence skipped, next TOKEN (or EOB if
//   remaining==0). tok[3:0]==15 -> MAT_EXT (mlen+=byte until !=0xFF), else COPY_RD.
// - COPY_RD: when output register empty/draining, issue read at
//   (wr_ptr - off) mod DEPTH -> COPY_WR. COPY_WR: load i_hist_rd_data into
//   output + history, mlen-=1; mlen==0 -> TOKEN or EOB (remaining==0), else
//   COPY_RD. Match throughput 1 byte / 2 clk; offset 1 (RLE) is hazard-free
//   because each read follows the previous write.
// - Every accepted payload byte decrements block remaining; o_block_done pulses
//   with the final decoded byte of the block (or on entering EOB if none).
// - EOB: accept 4 bytes; all zero -> IDLE (wr_ptr kept: window spans blocks);
//   non-zero first byte is treated as next frame's BSIZE byte 0.
// - Length arithmetic wraps modulo 2**LEN_W; off > DEPTH reads wrapped address.
// - i_enable low mid-block pauses at next byte boundary; no state lost.
// - Reset mid-operation: immediate return to reset values; pending output lost.
// CONFIGURATION
// YONGA_LZ4_ERR_CHECK_EN defined: o_error set and state ERROR (o_in_ready=0,
//   no output) on: off==0, off>DEPTH, length counter overflow, or block
//   remaining reaching 0 inside a token/offset/extension. Cleared only by reset.
// Not defined: no ERROR state, o_error tied 0, behaviour as above.
// TESTING
// 1 In: 07 00 00 00 44 41 42 43 44 04 00 00 00 00 00 -> out "ABCDABCDABCD",
//   o_block_done 1 pulse, o_idle=1 at end.
// 2 RLE: 04 00 00 00 16 5A 01 00 +end mark -> 11 x 0x5A, 2 clk/match byte.
// 3 Raw: 03 00 00 80 11 22 33 +end mark -> 11 22 33, no hist reads.
// 4 HIST_AW=4, 16 literals then off=16 mlen=20 -> correct wrapped replay,
//   wr_ptr/rd_addr wrap 15->0.
// 5 Test 1 with i_out_ready random 50% and i_in_valid gaps -> identical
//   output, o_out_data stable while valid & !ready, no drop/dup.
// 6 ERR_CHECK_EN, HIST_AW=4, off=0x0020 -> o_error=1, o_in_ready=0 until reset.

Source files
------------

// File: rtl/yonga_lz4_stream_decoder.sv
// LZ4 frame/block decoder between a compressed and a decompressed valid/ready stream.
// Uses an external circular history RAM. Define YONGA_LZ4_ERR_CHECK_EN to add error trapping.
module yonga_lz4_stream_decoder #(
  parameter int HIST_AW = 7,
  parameter int LEN_W   = 17,
  parameter int BLK_W   = 31
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_enable,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [7:0]         i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [7:0]         o_out_data,
  output logic               o_hist_rd_en,
  output logic [HIST_AW-1:0] o_hist_rd_addr,
  input  logic [7:0]         i_hist_rd_data,
  output logic               o_hist_wr_en,
  output logic [HIST_AW-1:0] o_hist_wr_addr,
  output logic [7:0]         o_hist_wr_data,
  output logic               o_idle,
  output logic               o_block_done,
  output logic               o_error
);
  typedef enum logic [3:0] {
    S_IDLE, S_BSIZE, S_TOKEN, S_LIT_EXT, S_LIT, S_OFFSET, S_MAT_EXT,
    S_COPY_RD, S_COPY_WR, S_RAW, S_EOB
`ifdef YONGA_LZ4_ERR_CHECK_EN
    , S_ERROR
`endif
  } state_t;

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic [23:0]        r_size;
  logic [BLK_W-1:0]   r_rem;
  logic [LEN_W-1:0]   r_lit;
  logic [LEN_W-1:0]   r_mlen;
  logic [15:0]        r_off;
  logic [3:0]         r_tok_m;
  logic [HIST_AW-1:0] r_wr_ptr;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_idle;
  logic               r_block_done;

  logic               w_can_load;
  logic               w_in_fire;
  logic               w_load;
  logic [7:0]         w_load_data;
  logic [BLK_W-1:0]   w_rem_dec;
  logic [31:0]        w_size;
  logic [15:0]        w_off;
  logic [LEN_W-1:0]   w_lit_sum;
  logic [LEN_W-1:0]   w_mlen_sum;

  assign w_can_load  = !r_out_valid || i_out_ready;
  assign w_in_fire   = i_in_valid && o_in_ready;
  assign w_load      = (r_state == S_COPY_WR) ||
                       (w_in_fire && (r_state == S_LIT || r_state == S_RAW));
  assign w_load_data = (r_state == S_COPY_WR) ? i_hist_rd_data : i_in_data;
  assign w_rem_dec   = r_rem - 1'b1;
  assign w_size      = {i_in_data, r_size};
  assign w_off       = {i_in_data, r_off[7:0]};

`ifdef YONGA_LZ4_ERR_CHECK_EN
  localparam logic [16:0] DEPTH = 17'(1 << HIST_AW);
  logic w_lit_ovf, w_mlen_ovf, w_err, r_error;
  assign {w_lit_ovf, w_lit_sum}   = {1'b0, r_lit} + (LEN_W+1)'(i_in_data);
  assign {w_mlen_ovf, w_mlen_sum} = {1'b0, r_mlen} + (LEN_W+1)'(i_in_data);

  // Malformed streams: zero/out-of-window offsets, length overflow, block ending mid-sequence.
  always_comb begin
    w_err = 1'b0;
    if (w_in_fire) begin
      case (r_state)
        S_TOKEN:   w_err = (w_rem_dec == '0);
        S_LIT_EXT: w_err = w_lit_ovf || (w_rem_dec == '0);
        S_OFFSET:  w_err = (r_cnt == 2'd0) ? (w_rem_dec == '0) :
                           ((w_off == '0) || ({1'b0, w_off} > DEPTH) ||
                            ((r_tok_m == 4'hF) && (w_rem_dec == '0)));
        S_MAT_EXT: w_err = w_mlen_ovf || ((w_rem_dec == '0) && (i_in_data == 8'hFF));
        default:   w_err = 1'b0;
      endcase
    end
  end
  assign o_error = r_error;
`else
  assign w_lit_sum  = r_lit + LEN_W'(i_in_data);
  assign w_mlen_sum = r_mlen + LEN_W'(i_in_data);
  assign o_error    = 1'b0;
`endif

  always_comb begin
    o_in_ready = 1'b0;
    if (i_enable) begin
      case (r_state)
        S_BSIZE, S_TOKEN, S_LIT_EXT, S_OFFSET, S_MAT_EXT, S_EOB: o_in_ready = 1'b1;
        S_LIT, S_RAW: o_in_ready = w_can_load;
        default:      o_in_ready = 1'b0;
      endcase
    end
  end

  // The write lands at the edge that loads the output, so a read one cycle later sees it.
  assign o_hist_rd_en   = (r_state == S_COPY_RD) && i_enable && w_can_load;
  assign o_hist_rd_addr = r_wr_ptr - r_off[HIST_AW-1:0];
  assign o_hist_wr_en   = w_load;
  assign o_hist_wr_addr = r_wr_ptr;
  assign o_hist_wr_data = w_load_data;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_idle         = r_idle;
  assign o_block_done   = r_block_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_size       <= '0;
      r_rem        <= '0;
      r_lit        <= '0;
      r_mlen       <= '0;
      r_off        <= '0;
      r_tok_m      <= '0;
      r_wr_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_idle       <= 1'b1;
      r_block_done <= 1'b0;
`ifdef YONGA_LZ4_ERR_CHECK_EN
      r_error      <= 1'b0;
`endif
    end else begin
      r_block_done <= 1'b0;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_wr_ptr    <= r_wr_ptr + 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (i_enable && i_in_valid) begin
          r_state <= S_BSIZE;
          r_idle  <= 1'b0;
        end
        // An end mark that is not all zero is the next frame's size word.
        S_BSIZE, S_EOB: if (w_in_fire) begin
          r_size <= {i_in_data, r_size[23:8]};
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            if (r_state == S_EOB && w_size == '0) begin
              r_state <= S_IDLE;
              r_idle  <= 1'b1;
            end else if (w_size[30:0] == '0) begin
              r_state      <= S_EOB;
              r_block_done <= 1'b1;
            end else begin
              r_rem   <= BLK_W'(w_size[30:0]);
              r_state <= w_size[31] ? S_RAW : S_TOKEN;
            end
          end
        end
        S_RAW: if (w_in_fire) begin
          r_rem <= w_rem_dec;
          if (w_rem_dec == '0) begin
            r_state      <= S_EOB;
            r_block_done <= 1'b1;
          end
        end
        S_TOKEN: if (w_in_fire) begin
          r_rem   <= w_rem_dec;
          r_tok_m <= i_in_data[3:0];
          r_lit   <= LEN_W'(i_in_data[7:4]);
          r_mlen  <= LEN_W'(i_in_data[3:0]) + LEN_W'(4);
          if (i_in_data[7:4] == 4'hF)      r_state <= S_LIT_EXT;
          else if (i_in_data[7:4] == 4'h0) r_state <= S_OFFSET;
          else                             r_state <= S_LIT;
        end
        S_LIT_EXT: if (w_in_fire) begin
          r_rem <= w_rem_dec;
          r_lit <= w_lit_sum;
          if (i_in_data != 8'hFF) r_state <= (w_lit_sum == '0) ? S_OFFSET : S_LIT;
        end
        S_LIT: if (w_in_fire) begin
          r_rem <= w_rem_dec;
          r_lit <= r_lit - 1'b1;
          if (r_lit == LEN_W'(1)) begin
            if (w_rem_dec == '0) begin
              r_state      <= S_EOB;
              r_block_done <= 1'b1;
            end else begin
              r_state <= S_OFFSET;
            end
          end
        end
        S_OFFSET: if (w_in_fire) begin
          r_rem <= w_rem_dec;
          if (r_cnt == 2'd0) begin
            r_off[7:0] <= i_in_data;
            r_cnt      <= 2'd1;
          end else begin
            r_off <= w_off;
            r_cnt <= 2'd0;
            if (w_off == '0) begin
              r_state      <= (w_rem_dec == '0) ? S_EOB : S_TOKEN;
              r_block_done <= (w_rem_dec == '0);
            end else begin
              r_state <= (r_tok_m == 4'hF) ? S_MAT_EXT : S_COPY_RD;
            end
          end
        end
        S_MAT_EXT: if (w_in_fire) begin
          r_rem  <= w_rem_dec;
          r_mlen <= w_mlen_sum;
          if (i_in_data != 8'hFF) r_state <= S_COPY_RD;
        end
        S_COPY_RD: if (o_hist_rd_en) r_state <= S_COPY_WR;
        S_COPY_WR: begin
          r_mlen <= r_mlen - 1'b1;
          if (r_mlen == LEN_W'(1)) begin
            r_state      <= (r_rem == '0) ? S_EOB : S_TOKEN;
            r_block_done <= (r_rem == '0);
          end else begin
            r_state <= S_COPY_RD;
          end
        end
        default: r_state <= r_state;
      endcase

`ifdef YONGA_LZ4_ERR_CHECK_EN
      if (w_err) begin
        r_state      <= S_ERROR;
        r_error      <= 1'b1;
        r_block_done <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_yonga_lz4_stream_decoder.sv
// Scoreboard bench for yonga_lz4_stream_decoder: reference LZ4 frame parser with a flat
// history queue, directed frames plus random frames with random back-pressure and pauses.
module tb_yonga_lz4_stream_decoder;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          i_enable = 1'b1;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [7:0]    i_in_data = 8'h00;
  logic          o_out_valid;
  logic          i_out_ready = 1'b1;
  logic [7:0]    o_out_data;
  logic          o_hist_rd_en;
  logic [AW-1:0] o_hist_rd_addr;
  logic [7:0]    hist_rd_data = 8'h00;
  logic          o_hist_wr_en;
  logic [AW-1:0] o_hist_wr_addr;
  logic [7:0]    o_hist_wr_data;
  logic          o_idle, o_block_done, o_error;

  yonga_lz4_stream_decoder #(.HIST_AW(AW), .LEN_W(17), .BLK_W(31)) dut (
    .clk(clk), .rstn(rstn), .i_enable(i_enable),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_hist_rd_en(o_hist_rd_en), .o_hist_rd_addr(o_hist_rd_addr), .i_hist_rd_data(hist_rd_data),
    .o_hist_wr_en(o_hist_wr_en), .o_hist_wr_addr(o_hist_wr_addr), .o_hist_wr_data(o_hist_wr_data),
    .o_idle(o_idle), .o_block_done(o_block_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (o_hist_wr_en) mem[o_hist_wr_addr] <= o_hist_wr_data;
    if (o_hist_rd_en) hist_rd_data <= mem[o_hist_rd_addr];
  end

  int n_vec = 0, n_fail = 0;
  int cyc = 0, rd_cnt = 0, bd_cnt = 0, exp_blocks = 0, exp_off = 0, gen_total = 0;
  bit rdy_rand = 0, gaps = 0, en_rand = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hist_q[$];
  int xfer_cyc[$];
  logic [AW-1:0] wr_exp = '0;
  bit hold_pend = 0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    i_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    i_enable    = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: everything sampled at negedge reflects what the next posedge will see.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rstn) begin
      wr_exp    = '0;
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("out_hold_valid", 32'(o_out_valid), 32'd1);
        check("out_hold_data", 32'(o_out_data), 32'(hold_data));
      end
      hold_pend = o_out_valid && !i_out_ready;
      hold_data = o_out_data;
      if (o_out_valid && i_out_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL out_extra: got byte %02h, required none", o_out_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("out_data", 32'(o_out_data), 32'(exp_b));
        end
      end
      if (o_hist_wr_en) begin
        check("hist_wr_addr", 32'(o_hist_wr_addr), 32'(wr_exp));
        wr_exp = wr_exp + 1'b1;
      end
      if (o_hist_rd_en) begin
        rd_cnt++;
        if (exp_off != 0) check("hist_rd_addr", 32'(o_hist_rd_addr), 32'(AW'(wr_exp - AW'(exp_off))));
      end
      if (o_block_done) bd_cnt++;
    end
  end

  task automatic emit(input logic [7:0] b);
    exp_q.push_back(b);
    hist_q.push_back(b);
  endtask

  // Reference: parse the frame with the LZ4 rules, history kept as one flat byte queue.
  task automatic model_stream(input bq_t s);
    int p, endp, lit, ml, off;
    logic [31:0] hdr;
    logic [7:0] tok, b;
    hdr = {s[3], s[2], s[1], s[0]};
    p = 4;
    while (hdr != 0 && p + 4 <= s.size()) begin
      exp_blocks++;
      endp = p + int'(hdr[30:0]);
      if (hdr[31]) begin
        while (p < endp) begin emit(s[p]); p++; end
      end else begin
        while (p < endp) begin
          tok = s[p]; p++;
          lit = int'(tok[7:4]);
          if (lit == 15) begin
            do begin b = s[p]; p++; lit += int'(b); end while (b == 8'hFF);
          end
          repeat (lit) begin emit(s[p]); p++; end
          if (p < endp) begin
            off = int'({s[p+1], s[p]}); p += 2;
            ml = int'(tok[3:0]) + 4;
            if (tok[3:0] == 4'hF) begin
              do begin b = s[p]; p++; ml += int'(b); end while (b == 8'hFF);
            end
            repeat (ml) emit(hist_q[hist_q.size() - off]);
          end
        end
      end
      hdr = {s[p+3], s[p+2], s[p+1], s[p]};
      p += 4;
    end
  endtask

  task automatic push_ext(inout bq_t q, input int r);
    int v = r;
    while (v >= 255) begin q.push_back(8'hFF); v -= 255; end
    q.push_back(8'(v));
  endtask

  task automatic push_word(inout bq_t q, input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
  endtask

  task automatic gen_stream(output bq_t s);
    int nblk;
    s = {};
    nblk = $urandom_range(1, 3);
    for (int bk = 0; bk < nblk; bk++) begin
      bq_t pl;
      bit raw;
      logic [31:0] sz;
      pl = {};
      raw = ($urandom_range(0, 3) == 0);
      if (raw) begin
        int n;
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        gen_total += n;
      end else begin
        int nseq;
        nseq = $urandom_range(1, 4);
        for (int sq = 0; sq < nseq; sq++) begin
          bit last;
          int lit, ml, off;
          logic [3:0] ln, mn;
          last = (sq == nseq - 1);
          lit = $urandom_range((last || gen_total == 0) ? 1 : 0, 30);
          ml = $urandom_range(4, 40);
          ln = (lit >= 15) ? 4'hF : 4'(lit);
          mn = (ml - 4 >= 15) ? 4'hF : 4'(ml - 4);
          pl.push_back({ln, last ? 4'h0 : mn});
          if (lit >= 15) push_ext(pl, lit - 15);
          for (int i = 0; i < lit; i++) pl.push_back(8'($urandom));
          gen_total += lit;
          if (!last) begin
            off = $urandom_range(1, (gen_total < DEPTH) ? gen_total : DEPTH);
            pl.push_back(8'(off));
            pl.push_back(8'(off >> 8));
            if (ml - 4 >= 15) push_ext(pl, ml - 19);
            gen_total += ml;
          end
        end
      end
      sz = 32'(pl.size());
      sz[31] = raw;
      push_word(s, sz);
      foreach (pl[i]) s.push_back(pl[i]);
    end
    push_word(s, 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard;
    bit acc;
    if (gaps) begin
      i_in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    guard = 0;
    acc = 0;
    while (!acc && guard < 3000) begin
      @(negedge clk);
      acc = o_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    i_in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_fail++;
      $display("FAIL in_accept: byte %02h not accepted, required acceptance within 3000 cycles", b);
    end
  endtask

  task automatic run_stream(input string nm, input bq_t s);
    int guard;
    exp_blocks = 0;
    bd_cnt = 0;
    rd_cnt = 0;
    xfer_cyc.delete();
    model_stream(s);
    foreach (s[i]) push_byte(s[i]);
    guard = 0;
    while ((exp_q.size() != 0 || !o_idle || o_out_valid) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      n_vec++; n_fail++;
      $display("FAIL %s_drain: %0d bytes still expected, required 0", nm, exp_q.size());
    end
    check({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_blocks"}, 32'(bd_cnt), 32'(exp_blocks));
    check({nm, "_idle"}, 32'(o_idle), 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle", 32'(o_idle), 32'd1);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_block_done", 32'(o_block_done), 32'd0);
    check("rst_hist_en", 32'({o_hist_rd_en, o_hist_wr_en}), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    s = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h44, 8'h41, 8'h42, 8'h43, 8'h44,
          8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    gen_total += 12;
    run_stream("abcd", s);
    check("abcd_count", 32'(xfer_cyc.size()), 32'd12);

    s = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h16, 8'h5A, 8'h01, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00};
    gen_total += 11;
    exp_off = 1;
    run_stream("rle", s);
    exp_off = 0;
    check("rle_reads", 32'(rd_cnt), 32'd10);
    check("rle_count", 32'(xfer_cyc.size()), 32'd11);
    if (xfer_cyc.size() == 11) check("rle_rate", 32'(xfer_cyc[10] - xfer_cyc[1]), 32'd18);

    s = '{8'h03, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    gen_total += 3;
    run_stream("raw", s);
    check("raw_reads", 32'(rd_cnt), 32'd0);

    s = '{8'h15, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01};
    for (int i = 0; i < 16; i++) s.push_back(8'(8'h60 + i));
    s.push_back(8'h10); s.push_back(8'h00); s.push_back(8'h01);
    push_word(s, 32'd0);
    gen_total += 36;
    exp_off = 16;
    run_stream("wrap", s);
    exp_off = 0;
    check("wrap_reads", 32'(rd_cnt), 32'd20);

    rdy_rand = 1; gaps = 1;
    s = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h44, 8'h41, 8'h42, 8'h43, 8'h44,
          8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    gen_total += 12;
    run_stream("abcd_bp", s);

    en_rand = 1;
    for (int k = 0; k < 8; k++) begin
      gen_stream(s);
      run_stream("rand", s);
    end
    rdy_rand = 0; gaps = 0; en_rand = 0;
    @(posedge clk); #1;

`ifdef YONGA_LZ4_ERR_CHECK_EN
    exp_q.push_back(8'h41);
    s = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h14, 8'h41, 8'h20, 8'h00};
    foreach (s[i]) push_byte(s[i]);
    repeat (3) @(negedge clk);
    check("err_flag", 32'(o_error), 32'd1);
    check("err_out_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    i_in_valid = 1'b1;
    i_in_data  = 8'h00;
    repeat (5) begin
      @(negedge clk);
      check("err_in_ready", 32'(o_in_ready), 32'd0);
      check("err_sticky", 32'(o_error), 32'd1);
    end
    i_in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("err_reset_clear", 32'(o_error), 32'd0);
    check("err_reset_idle", 32'(o_idle), 32'd1);
    rstn = 1'b1;
`else
    check("no_error", 32'(o_error), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
